// File: rtl/ip_frame_sched_pkg.sv
// Shared types and timing defaults for the edge-detection frame scheduler.
package ip_frame_sched_pkg;

    localparam int CW = 11;

    // VGA 640x480 and SVGA 800x600 timing sets.
    localparam int H_LIMIT_DEF    = 800;
    localparam int H_START_DEF    = 0;
    localparam int V_LIMIT_DEF    = 525;
    localparam int REF_WIDTH_DEF  = 640;
    localparam int H_LIMIT_SVGA   = 1056;
    localparam int H_START_SVGA   = 216;
    localparam int V_LIMIT_SVGA   = 628;
    localparam int REF_WIDTH_SVGA = 800;

    typedef enum logic [2:0] {
        RAW    = 3'd0,
        BLUR   = 3'd1,
        GRAD   = 3'd2,
        NONMAX = 3'd3,
        HYSTER = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    // sel is SW[4:1]; the highest set switch wins.
    function automatic mode_e decode_mode(input logic [3:0] sel);
        if (sel[3])      return RAW;
        else if (sel[2]) return BLUR;
        else if (sel[1]) return GRAD;
        else if (sel[0]) return NONMAX;
        else             return HYSTER;
    endfunction

endpackage

// File: rtl/ip_frame_sched_if.sv
// Control/status bundle between the read side and the line-buffer scheduler.
interface ip_frame_sched_if
    import ip_frame_sched_pkg::*;
#(
    parameter int N_STAGES = 4
);
    logic                i_is_new_read;
    logic [4:0]          i_SW;
    logic [3:0]          i_seg_width;
    logic [CW-1:0]       o_h_cursor;
    logic [CW-1:0]       o_v_cursor;
    logic                o_wr_en;
    logic                o_line_shift;
    logic                o_frame_end;
    logic                o_resync;
    logic [N_STAGES-1:0] o_stage_valid;
    logic [2:0]          o_mode;
    logic [3:0]          o_seg_width;

    modport master (
        output i_is_new_read, i_SW, i_seg_width,
        input  o_h_cursor, o_v_cursor, o_wr_en, o_line_shift, o_frame_end,
        input  o_resync, o_stage_valid, o_mode, o_seg_width
    );

    modport slave (
        input  i_is_new_read, i_SW, i_seg_width,
        output o_h_cursor, o_v_cursor, o_wr_en, o_line_shift, o_frame_end,
        output o_resync, o_stage_valid, o_mode, o_seg_width
    );
endinterface

// File: rtl/ip_cursor_cnt.sv
// H/V pixel cursor with wrap; line_shift and frame_end are registered
// from the next cursor value so they line up with h = H_LIMIT-1.
module ip_cursor_cnt
    import ip_frame_sched_pkg::*;
#(
    parameter int H_LIMIT = H_LIMIT_DEF,
    parameter int V_LIMIT = V_LIMIT_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clear,
    input  logic          i_en,
    output logic [CW-1:0] o_h,
    output logic [CW-1:0] o_v,
    output logic          o_line_shift,
    output logic          o_frame_end
);

    localparam logic [CW-1:0] H_MAX = CW'(H_LIMIT - 1);
    localparam logic [CW-1:0] V_MAX = CW'(V_LIMIT - 1);

    logic [CW-1:0] h_q, h_d, v_q, v_d;
    logic          line_shift_q, line_shift_d;
    logic          frame_end_q, frame_end_d;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (i_clear) begin
            h_d = '0;
            v_d = '0;
        end else if (i_en) begin
            if (h_q == H_MAX) begin
                h_d = '0;
                v_d = (v_q == V_MAX) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
        line_shift_d = (i_clear || i_en) && (h_d == H_MAX) && (v_d != V_MAX);
        frame_end_d  = (i_clear || i_en) && (h_d == H_MAX) && (v_d == V_MAX);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_q          <= '0;
            v_q          <= '0;
            line_shift_q <= 1'b0;
            frame_end_q  <= 1'b0;
        end else begin
            h_q          <= h_d;
            v_q          <= v_d;
            line_shift_q <= line_shift_d;
            frame_end_q  <= frame_end_d;
        end
    end

    assign o_h          = h_q;
    assign o_v          = v_q;
    assign o_line_shift = line_shift_q;
    assign o_frame_end  = frame_end_q;

endmodule

// File: rtl/ip_frame_sched.sv
// Frame scheduler: run/hold FSM, frame-boundary control latching,
// misaligned-strobe resync and sticky per-stage fill tracking.
module ip_frame_sched
    import ip_frame_sched_pkg::*;
#(
    parameter int H_LIMIT  = H_LIMIT_DEF,
    parameter int H_START  = H_START_DEF,
    parameter int V_LIMIT  = V_LIMIT_DEF,
    parameter int N_STAGES = 4
) (
    input logic              i_clk,
    input logic              i_rst_n,
    ip_frame_sched_if.slave  bus
);

    localparam logic [CW-1:0] H_MAX     = CW'(H_LIMIT - 1);
    localparam logic [CW-1:0] H_START_C = CW'(H_START);

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [3:0]          seg_q, seg_d;
    logic [N_STAGES-1:0] valid_q, valid_d;
    logic                wr_en_q, wr_en_d;
    logic                resync_q, resync_d;

    logic [CW-1:0] h_cnt, v_cnt;
    logic          line_shift, frame_end;
    logic          cnt_clear, cnt_en, misaligned, latch;

    ip_cursor_cnt #(
        .H_LIMIT (H_LIMIT),
        .V_LIMIT (V_LIMIT)
    ) u_cursor (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (cnt_clear),
        .i_en         (cnt_en),
        .o_h          (h_cnt),
        .o_v          (v_cnt),
        .o_line_shift (line_shift),
        .o_frame_end  (frame_end)
    );

    // A strobe at the origin or on the frame-end pixel is in step with us.
    assign misaligned = (state_q != S_IDLE) && bus.i_is_new_read && !frame_end
                        && !((h_cnt == '0) && (v_cnt == '0));
    assign cnt_en     = (state_q != S_IDLE);
    assign cnt_clear  = ((state_q == S_IDLE) && bus.i_is_new_read) || misaligned;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        seg_d    = seg_q;
        valid_d  = valid_q;
        resync_d = 1'b0;
        latch    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.i_is_new_read) begin
                    state_d = S_RUN;
                    latch   = 1'b1;
                    valid_d = '0;
                end
            end
            S_RUN: begin
                if (frame_end) begin
                    latch   = 1'b1;
                    state_d = bus.i_SW[0] ? S_HOLD : S_RUN;
                end
            end
            S_HOLD: begin
                if (frame_end && !bus.i_SW[0]) begin
                    latch   = 1'b1;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Stage k has a full 3-row window once line k has been written.
        for (int k = 0; k < N_STAGES; k++) begin
            if ((state_q == S_RUN) && (h_cnt == H_MAX) && (v_cnt == CW'(k)))
                valid_d[k] = 1'b1;
        end

        if (misaligned) begin
            state_d  = S_RUN;
            latch    = 1'b1;
            valid_d  = '0;
            resync_d = 1'b1;
        end

        if (latch) begin
            mode_d = decode_mode(bus.i_SW[4:1]);
            seg_d  = bus.i_seg_width;
        end

        wr_en_d = (state_d == S_RUN);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            mode_q   <= HYSTER;
            seg_q    <= '0;
            valid_q  <= '0;
            wr_en_q  <= 1'b0;
            resync_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            seg_q    <= seg_d;
            valid_q  <= valid_d;
            wr_en_q  <= wr_en_d;
            resync_q <= resync_d;
        end
    end

    assign bus.o_h_cursor    = h_cnt - H_START_C;
    assign bus.o_v_cursor    = v_cnt;
    assign bus.o_wr_en       = wr_en_q;
    assign bus.o_line_shift  = line_shift;
    assign bus.o_frame_end   = frame_end;
    assign bus.o_resync      = resync_q;
    assign bus.o_stage_valid = valid_q;
    assign bus.o_mode        = mode_q;
    assign bus.o_seg_width   = seg_q;

endmodule

// File: tb/tb_ip_frame_sched.sv
// Directed bench for ip_frame_sched on an 8x4 frame: fill, latching,
// freeze/hold, aligned and misaligned strobes, async reset.
module tb_ip_frame_sched;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int NS = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   vector_count = 0;
    int   miscompare_count = 0;
    int   cur_step = -1;

    always #5 clk = ~clk;

    ip_frame_sched_if #(.N_STAGES(NS)) bus ();

    ip_frame_sched #(
        .H_LIMIT  (H),
        .H_START  (0),
        .V_LIMIT  (V),
        .N_STAGES (NS)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vector_count++;
        if (observed !== expected) begin
            miscompare_count++;
            $display("[TB] FAIL %s step %0d: got %0d, expected %0d", tag, cur_step, observed, expected);
        end
    endtask

    task automatic checkAll(input int eh, input int ev, input int ewr, input int els, input int efe,
                            input int ers, input int evalid, input int emode, input int eseg);
        checkOutput("h_cursor",    32'(bus.o_h_cursor),    eh);
        checkOutput("v_cursor",    32'(bus.o_v_cursor),    ev);
        checkOutput("wr_en",       32'(bus.o_wr_en),       ewr);
        checkOutput("line_shift",  32'(bus.o_line_shift),  els);
        checkOutput("frame_end",   32'(bus.o_frame_end),   efe);
        checkOutput("resync",      32'(bus.o_resync),      ers);
        checkOutput("stage_valid", 32'(bus.o_stage_valid), evalid);
        checkOutput("mode",        32'(bus.o_mode),        emode);
        checkOutput("seg_width",   32'(bus.o_seg_width),   eseg);
    endtask

    task automatic applyStimulus(input logic strobe, input logic [4:0] sw, input logic [3:0] seg);
        bus.i_is_new_read = strobe;
        bus.i_SW          = sw;
        bus.i_seg_width   = seg;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [4:0] sw;
        logic [3:0] seg;
        logic       strobe;
        int         h, v, c;

        rst_n             = 1'b0;
        bus.i_is_new_read = 1'b0;
        bus.i_SW          = 5'b0;
        bus.i_seg_width   = 4'd0;

        @(negedge clk);
        checkAll(0, 0, 0, 0, 0, 0, 0, 4, 0);
        rst_n = 1'b1;

        repeat (8) applyStimulus(1'b0, 5'b00000, 4'd9);
        checkAll(0, 0, 0, 0, 0, 0, 0, 4, 0);

        applyStimulus(1'b1, 5'b00000, 4'd9);
        cur_step = 0;
        checkAll(0, 0, 1, 0, 0, 0, 0, 4, 9);

        // Frame 1 run, frame 2 frozen, frame 3 running again.
        for (int n = 1; n <= 83; n++) begin
            c      = n - 1;
            sw     = (c >= 39) ? 5'b00100 : (c >= 19) ? 5'b01001 : (c >= 11) ? 5'b01000 : 5'b00000;
            seg    = (c >= 39) ? 4'd5 : (c >= 11) ? 4'd3 : 4'd9;
            strobe = (c == 63) || (c == 64);
            applyStimulus(strobe, sw, seg);
            cur_step = n;
            h = n % H;
            v = (n / H) % V;
            checkAll(h, v,
                     ((n >= 32) && (n < 64)) ? 0 : 1,
                     ((h == H - 1) && (v != V - 1)) ? 1 : 0,
                     ((h == H - 1) && (v == V - 1)) ? 1 : 0,
                     0,
                     (n >= 32) ? 15 : ((1 << (n / H)) - 1),
                     (n < 32) ? 4 : (n < 64) ? 1 : 2,
                     (n < 32) ? 9 : (n < 64) ? 3 : 5);
        end

        // Misaligned strobe at h=3, v=2.
        applyStimulus(1'b1, 5'b00100, 4'd5);
        cur_step = 100;
        checkAll(0, 0, 1, 0, 0, 1, 0, 2, 5);

        for (int p = 1; p <= 13; p++) begin
            applyStimulus(1'b0, 5'b00100, 4'd5);
            cur_step = 100 + p;
            h = p % H;
            v = p / H;
            checkAll(h, v, 1, ((h == H - 1) && (v != V - 1)) ? 1 : 0, 0, 0,
                     (1 << v) - 1, 2, 5);
        end

        // Asynchronous reset at h=5, v=1, away from any clock edge.
        rst_n = 1'b0;
        #1;
        cur_step = 200;
        checkAll(0, 0, 0, 0, 0, 0, 0, 4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) applyStimulus(1'b0, 5'b00100, 4'd5);
        cur_step = 201;
        checkAll(0, 0, 0, 0, 0, 0, 0, 4, 0);

        applyStimulus(1'b1, 5'b00100, 4'd5);
        cur_step = 202;
        checkAll(0, 0, 1, 0, 0, 0, 0, 2, 5);
        bus.i_is_new_read = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
        $finish;
    end

endmodule
